// File: rtl/vid_timing_pkg.sv
// Video timing mode table shared by the timing generator and anything that
// needs to know the geometry of a mode.
package vid_timing_pkg;

    localparam int FW = 12;

    typedef struct packed {
        logic [FW-1:0] h_act;
        logic [FW-1:0] h_fp;
        logic [FW-1:0] h_sync;
        logic [FW-1:0] h_tot;
        logic [FW-1:0] v_act;
        logic [FW-1:0] v_fp;
        logic [FW-1:0] v_sync;
        logic [FW-1:0] v_tot;
        logic          h_pos;  // 1: hsync active high
        logic          v_pos;  // 1: vsync active high
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } vt_state_e;

    localparam mode_t MODE_TABLE [4] = '{
        '{12'd640,  12'd16,  12'd96,  12'd800,  12'd480,  12'd10, 12'd2, 12'd525,  1'b0, 1'b0},
        '{12'd1280, 12'd110, 12'd40,  12'd1650, 12'd720,  12'd5,  12'd5, 12'd750,  1'b1, 1'b1},
        '{12'd1920, 12'd88,  12'd44,  12'd2200, 12'd1080, 12'd4,  12'd5, 12'd1125, 1'b1, 1'b1},
        '{12'd800,  12'd40,  12'd128, 12'd1056, 12'd600,  12'd1,  12'd4, 12'd628,  1'b1, 1'b1}
    };

endpackage

// File: rtl/vid_timing_if.sv
// Signal bundle around the video timing generator (everything except clock/reset).
interface vid_timing_if #(
    parameter int CW = 12
);
    // mode_load is a one-cycle request (no ready); mode_ack is a one-cycle
    // pulse coinciding with pixel (0,0) of the newly applied mode.
    logic          enable;
    logic [1:0]    mode_req;
    logic          mode_load;
    logic          mode_ack;
    logic [1:0]    cur_mode;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        output enable, mode_req, mode_load,
        input  mode_ack, cur_mode, sx, sy, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        input  enable, mode_req, mode_load,
        output mode_ack, cur_mode, sx, sy, hsync, vsync, de, line_start, frame_start
    );

endinterface

// File: rtl/vid_timing.sv
// Multi-mode raster timing generator with frame-aligned mode switching.
// Outputs are registered and describe the counter position one enabled edge earlier.
module vid_timing
    import vid_timing_pkg::*;
#(
    parameter int CW         = 12,
    parameter int RESET_MODE = 0
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic          enable,
    input  logic [1:0]    mode_req,
    input  logic          mode_load,
    output logic          mode_ack,
    output logic [1:0]    cur_mode,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [1:0] RST_MODE   = 2'(RESET_MODE);
    localparam mode_t      RST_TIMING = MODE_TABLE[RST_MODE];

    vt_state_e     state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    mode_q, mode_d;
    logic          apply_q, apply_d;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;

    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic          ls_q, ls_d, fs_q, fs_d, ack_q, ack_d;
    logic [1:0]    cur_q, cur_d;

    mode_t         m;
    logic [CW-1:0] h_act, h_tot, v_act, v_tot;
    logic [CW-1:0] hs_beg, hs_end, vs_beg, vs_end;
    logic          h_last, v_last, frame_end;

    assign m      = MODE_TABLE[mode_q];
    assign h_act  = CW'(m.h_act);
    assign h_tot  = CW'(m.h_tot);
    assign v_act  = CW'(m.v_act);
    assign v_tot  = CW'(m.v_tot);
    assign hs_beg = CW'(m.h_act) + CW'(m.h_fp);
    assign hs_end = hs_beg + CW'(m.h_sync);
    assign vs_beg = CW'(m.v_act) + CW'(m.v_fp);
    assign vs_end = vs_beg + CW'(m.v_sync);

    assign h_last    = (hc_q == h_tot - CW'(1));
    assign v_last    = (vc_q == v_tot - CW'(1));
    assign frame_end = h_last && v_last;

    // Mode-switch FSM: a load at the frame-end edge bypasses the pending register.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        apply_d = apply_q;
        if (enable) begin
            apply_d = 1'b0;
        end
        if (enable && frame_end && mode_load) begin
            mode_d  = mode_req;
            apply_d = 1'b1;
            state_d = ST_IDLE;
        end else if (mode_load) begin
            pend_d  = mode_req;
            state_d = ST_PEND;
        end else if (enable && frame_end && state_q == ST_PEND) begin
            mode_d  = pend_q;
            apply_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        hc_d  = hc_q;
        vc_d  = vc_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        ls_d  = ls_q;
        fs_d  = fs_q;
        ack_d = ack_q;
        cur_d = cur_q;
        if (enable) begin
            sx_d  = hc_q;
            sy_d  = vc_q;
            de_d  = (hc_q < h_act) && (vc_q < v_act);
            hs_d  = ((hc_q >= hs_beg) && (hc_q < hs_end)) ? m.h_pos : ~m.h_pos;
            vs_d  = ((vc_q >= vs_beg) && (vc_q < vs_end)) ? m.v_pos : ~m.v_pos;
            ls_d  = (hc_q == '0);
            fs_d  = (hc_q == '0) && (vc_q == '0);
            ack_d = apply_q;
            cur_d = mode_q;
            hc_d  = h_last ? '0 : hc_q + CW'(1);
            if (h_last) begin
                vc_d = v_last ? '0 : vc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q <= ST_IDLE;
            pend_q  <= RST_MODE;
            mode_q  <= RST_MODE;
            apply_q <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~RST_TIMING.h_pos;
            vs_q    <= ~RST_TIMING.v_pos;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            ack_q   <= 1'b0;
            cur_q   <= RST_MODE;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            apply_q <= apply_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            ack_q   <= ack_d;
            cur_q   <= cur_d;
        end
    end

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign mode_ack    = ack_q;
    assign cur_mode    = cur_q;

endmodule

// File: tb/tb_vid_timing.sv
// Bench for vid_timing: linear-pixel-index reference model plus directed
// scenarios for mode switching, enable freeze and asynchronous reset.
module tb_vid_timing;

    localparam int CW = 12;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b0;

    vid_timing_if #(.CW(CW)) bus ();

    vid_timing #(.CW(CW), .RESET_MODE(0)) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .enable     (bus.enable),
        .mode_req   (bus.mode_req),
        .mode_load  (bus.mode_load),
        .mode_ack   (bus.mode_ack),
        .cur_mode   (bus.cur_mode),
        .sx         (bus.sx),
        .sy         (bus.sy),
        .hsync      (bus.hsync),
        .vsync      (bus.vsync),
        .de         (bus.de),
        .line_start (bus.line_start),
        .frame_start(bus.frame_start)
    );

    always #5 clk_pix = ~clk_pix;

    // Mode geometry written straight from the mode table
    int t_hact [4] = '{640, 1280, 1920, 800};
    int t_hfp  [4] = '{16, 110, 88, 40};
    int t_hsy  [4] = '{96, 40, 44, 128};
    int t_htot [4] = '{800, 1650, 2200, 1056};
    int t_vact [4] = '{480, 720, 1080, 600};
    int t_vfp  [4] = '{10, 5, 4, 1};
    int t_vsy  [4] = '{2, 5, 5, 4};
    int t_vtot [4] = '{525, 750, 1125, 628};
    bit t_pos  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    int checks = 0;
    int errors = 0;

    // Model: m_p is the linear pixel index inside the frame the counters hold
    int m_mode, m_p, m_pend;
    bit m_pend_v, m_apply;
    int e_sx, e_sy, e_cur;
    bit e_de, e_hs, e_vs, e_ls, e_fs, e_ack;

    task finish_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        if (errors >= 20) finish_run();
    endtask

    function automatic logic [31:0] obs_vec();
        return {bus.sx, bus.sy, bus.de, bus.hsync, bus.vsync, bus.line_start,
                bus.frame_start, bus.mode_ack, bus.cur_mode};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {12'(e_sx), 12'(e_sy), e_de, e_hs, e_vs, e_ls, e_fs, e_ack, 2'(e_cur)};
    endfunction

    task model_reset;
        m_mode = 0; m_p = 0; m_pend = 0; m_pend_v = 0; m_apply = 0;
        e_sx = 0; e_sy = 0; e_cur = 0;
        e_de = 0; e_ls = 0; e_fs = 0; e_ack = 0;
        e_hs = !t_pos[0]; e_vs = !t_pos[0];
    endtask

    task model_edge(input bit en, input bit ld, input int req);
        int ht, x, y, hs0, vs0;
        bit last;
        if (en) begin
            ht  = t_htot[m_mode];
            x   = m_p % ht;
            y   = m_p / ht;
            hs0 = t_hact[m_mode] + t_hfp[m_mode];
            vs0 = t_vact[m_mode] + t_vfp[m_mode];
            e_sx  = x;
            e_sy  = y;
            e_de  = (x < t_hact[m_mode]) && (y < t_vact[m_mode]);
            e_hs  = (x >= hs0 && x < hs0 + t_hsy[m_mode]) ? t_pos[m_mode] : !t_pos[m_mode];
            e_vs  = (y >= vs0 && y < vs0 + t_vsy[m_mode]) ? t_pos[m_mode] : !t_pos[m_mode];
            e_ls  = (x == 0);
            e_fs  = (m_p == 0);
            e_ack = m_apply;
            e_cur = m_mode;
            last  = (m_p == ht * t_vtot[m_mode] - 1);
            m_apply = 0;
            if (last) begin
                m_p = 0;
                if (ld) begin
                    m_mode = req; m_apply = 1; m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_mode = m_pend; m_apply = 1; m_pend_v = 0;
                end
            end else begin
                m_p++;
                if (ld) begin m_pend_v = 1; m_pend = req; end
            end
        end else if (ld) begin
            m_pend_v = 1; m_pend = req;
        end
    endtask

    task tick(input bit en, input bit ld, input int req);
        bus.enable    = en;
        bus.mode_load = ld;
        bus.mode_req  = 2'(req);
        @(posedge clk_pix);
        model_edge(en, ld, req);
        #1;
        chk("outputs", obs_vec(), exp_vec());
    endtask

    // Raises reset between clock edges and checks the outputs clear at once.
    task do_reset;
        #2;
        rst_pix = 1'b1;
        #1;
        model_reset();
        chk("rst_clear", obs_vec(), exp_vec());
        bus.enable    = 1'b1;
        bus.mode_load = 1'b0;
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        rst_pix = 1'b0;
    endtask

    initial begin
        #(30_000_000);
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        finish_run();
    end

    initial begin
        int de_cnt, hl_cnt, hl_first, fs_gap, ls_first, hh_cnt, hh_first;
        int ack_cnt, n, pos1, pos2, req, k;
        bit en, ld, seen1, frozen;
        logic [31:0] snap;

        bus.enable = 1'b1; bus.mode_load = 1'b0; bus.mode_req = 2'd0;
        do_reset();

        // Mode 0 frame with enable held high; request mode 2 at (100,100)
        tick(1, 0, 0);
        chk("first_px", {bus.de, bus.line_start, bus.frame_start, bus.sx, bus.sy},
            {3'b111, 24'd0});
        de_cnt = bus.de; hl_cnt = 0; hl_first = -1; fs_gap = 0;
        for (int i = 1; i <= 430000 && fs_gap == 0; i++) begin
            tick(1, (e_sx == 100 && e_sy == 100), 2);
            if (bus.frame_start) fs_gap = i;
            else begin
                de_cnt += bus.de;
                if (bus.sy == 0 && !bus.hsync) begin
                    hl_cnt++;
                    if (hl_first < 0) hl_first = bus.sx;
                end
            end
        end
        chk("fs_period", fs_gap, 420000);
        chk("de_count", de_cnt, 307200);
        chk("hs_low_len", hl_cnt, 96);
        chk("hs_low_start", hl_first, 656);
        chk("switch_2", {bus.mode_ack, bus.cur_mode, bus.sx, bus.sy}, {1'b1, 2'd2, 24'd0});

        // First line of mode 2
        ls_first = 0; hh_cnt = 0; hh_first = -1;
        for (int i = 1; i <= 2300 && ls_first == 0; i++) begin
            tick(1, 0, 0);
            if (bus.line_start) ls_first = i;
            else if (bus.hsync) begin
                hh_cnt++;
                if (hh_first < 0) hh_first = bus.sx;
            end
        end
        chk("line_len_2", ls_first, 2200);
        chk("hs_high_len", hh_cnt, 44);
        chk("hs_high_start", hh_first, 2008);
        do_reset();

        // Two requests in one frame (1 then 3) with random enable gaps
        tick(1, 0, 0);
        chk("first_px_b", {bus.de, bus.line_start, bus.frame_start}, 3'b111);
        pos1 = $urandom_range(1000, 200000);
        pos2 = $urandom_range(pos1 + 1, 419000);
        n = 0; ack_cnt = 0; seen1 = 0;
        for (int i = 0; i < 440000 && n < 420300; i++) begin
            en  = ($urandom_range(0, 499) != 0);
            ld  = 1'b0;
            req = $urandom_range(0, 3);
            if (en && n == pos1) begin ld = 1'b1; req = 1; end
            if (en && n == pos2) begin ld = 1'b1; req = 3; end
            tick(en, ld, req);
            if (en) begin
                n++;
                if (bus.mode_ack) ack_cnt++;
                if (bus.cur_mode == 2'd1) seen1 = 1'b1;
            end
        end
        chk("b_budget", n, 420300);
        chk("single_ack", ack_cnt, 1);
        chk("mode_3", bus.cur_mode, 3);
        chk("never_1", seen1, 0);

        // Pending request, then asynchronous reset mid-frame
        tick(1, 1, $urandom_range(0, 3));
        k = $urandom_range(1, 20);
        for (int i = 0; i < k; i++) tick(1, 0, 0);
        do_reset();

        // Mode 0 frame: enable freeze at (639,479), then load on the frame-end edge
        tick(1, 0, 0);
        chk("first_px_c", {bus.de, bus.line_start, bus.frame_start}, 3'b111);
        ack_cnt = 0;
        for (int i = 0; i < 400000 && !(e_sx == 639 && e_sy == 479); i++) begin
            tick(1, 0, 0);
            ack_cnt += bus.mode_ack;
        end
        chk("reach_639", {bus.sx, bus.sy}, {12'd639, 12'd479});
        snap = obs_vec(); frozen = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(0, 0, 0);
            if (obs_vec() !== snap) frozen = 1'b0;
        end
        chk("frozen", frozen, 1);
        tick(1, 0, 0);
        chk("resume", {bus.sx, bus.sy, bus.de}, {12'd640, 12'd479, 1'b0});
        for (int i = 0; i < 100000 && !(e_sx == 798 && e_sy == 524); i++) begin
            tick(1, 0, 0);
            ack_cnt += bus.mode_ack;
        end
        chk("reach_end", {bus.sx, bus.sy}, {12'd798, 12'd524});
        chk("no_ack_after_rst", ack_cnt, 0);
        chk("mode_0_kept", bus.cur_mode, 0);
        tick(1, 1, 1);
        tick(1, 0, 0);
        chk("fe_load", {bus.mode_ack, bus.frame_start, bus.cur_mode, bus.sx, bus.sy},
            {1'b1, 1'b1, 2'd1, 24'd0});
        for (int i = 0; i < 20; i++) tick(1, 0, 0);
        finish_run();
    end

endmodule

// File: doc/vid_timing.md
VID_TIMING -- requirements
Module: vid_timing

Interface
REQ-001 SHALL have parameter CW, default 12, width of sx/sy and internal counters.
REQ-002 SHALL have parameter RESET_MODE, default 0, mode active after reset.
REQ-003 SHALL have port clk_pix, input, 1, pixel clock; the single clock.
REQ-004 SHALL have port rst_pix, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, advance timing when high, hold all state when low.
REQ-006 SHALL have port mode_req, input, 2, requested mode index.
REQ-007 SHALL have port mode_load, input, 1, one-cycle request to switch to mode_req.
REQ-008 SHALL have port mode_ack, output, 1, one-cycle pulse when a requested mode takes effect.
REQ-009 SHALL have port cur_mode, output, 2, mode governing the current output pixel.
REQ-010 SHALL have port sx, output, CW, horizontal position of the current output pixel.
REQ-011 SHALL have port sy, output, CW, vertical position of the current output pixel.
REQ-012 SHALL have ports hsync, vsync, output, 1 each, syncs at the per-mode polarity.
REQ-013 SHALL have port de, output, 1, high inside the active area.
REQ-014 SHALL have ports line_start, frame_start, output, 1 each, high at (0,y) and (0,0) respectively.

Function
REQ-015 SHALL support the mode table (active, front porch, sync, total; polarity), horizontal / vertical:
- mode 0: 640,16,96,800 / 480,10,2,525; negative/negative
- mode 1: 1280,110,40,1650 / 720,5,5,750; positive/positive
- mode 2: 1920,88,44,2200 / 1080,4,5,1125; positive/positive
- mode 3: 800,40,128,1056 / 600,1,4,628; positive/positive
REQ-016 SHALL keep internal counters hc/vc; on an enabled edge hc wraps from H_TOT-1 to 0; vc increments on hc wrap and wraps from V_TOT-1 to 0.
REQ-017 SHALL register all outputs from hc/vc with exactly one cycle of latency, so outputs on a cycle describe the position held by hc/vc on the previous enabled edge.
REQ-018 SHALL assert de when sx<H_ACT and sy<V_ACT.
REQ-019 SHALL assert hsync active when H_ACT+HFP <= sx < H_ACT+HFP+HS, and vsync likewise on sy; inactive level is the complement.
REQ-020 SHALL hold counters and all outputs unchanged, including pulses, while enable is low.
REQ-021 SHALL implement a two-state FSM, IDLE and PEND: mode_load in either state captures mode_req into a pending register and enters PEND; a later mode_load overwrites the pending value.
REQ-022 SHALL apply a pending mode only on the enabled edge where hc=H_TOT-1 and vc=V_TOT-1 of the current mode, then return to IDLE.
REQ-023 SHALL give mode_load priority if it coincides with that frame-end edge: apply mode_req directly.
REQ-024 SHALL assert mode_ack and frame_start together with the first output pixel (0,0) of the new mode, and update cur_mode on the same cycle.
REQ-025 SHALL treat mode_load equal to cur_mode as a normal request: wait for the frame end, then acknowledge.

Reset
REQ-026 SHALL, on rst_pix regardless of clock or enable, clear hc, vc, sx, sy, de, line_start, frame_start and mode_ack; enter IDLE; set cur_mode=RESET_MODE; drive hsync/vsync at RESET_MODE's inactive level.
REQ-027 SHALL present pixel (0,0) with de, line_start and frame_start high on the first enabled edge after reset release.
REQ-028 SHALL discard a pending request on reset mid-frame.

Structure
REQ-029 SHALL place the mode_t struct (H/V active, FP, sync, total, polarity) and the constant four-entry mode table in package vid_timing_pkg.
REQ-030 SHALL be a single module with no sub-modules; timing fields are read from the package table indexed by the active mode register.

Verification
REQ-031 SHALL check reset to mode 0, enable held high: frame_start every 420000 cycles; hsync low for 96 cycles starting at sx=656; de count per frame = 307200.
REQ-032 SHALL check mode_load=1 with mode_req=2 at mode-0 position (100,100): mode_ack, frame_start and cur_mode=2 appear together at the next (0,0); new line length 2200; hsync high at sx=2008..2051.
REQ-033 SHALL check two mode_loads, 1 then 3, within one frame: only mode 3 applied, single mode_ack.
REQ-034 SHALL check mode_load coinciding with the frame-end edge, mode_req=1: applied at the immediately following (0,0).
REQ-035 SHALL check enable low for 50 cycles at sx=639, sy=479: all outputs frozen, then resume at sx=640 with de=0.
REQ-036 SHALL check rst_pix asserted asynchronously mid-frame while PEND: outputs clear without a clock edge; no mode_ack after release.
